slave_bus_master: RTL and testbench

// Bus-master sequencer directly upstream of the DLX slave Control block.

---
 rtl/slave_bus_master.sv | 107 ++++++++++
 tb/tb_slave_bus_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/slave_bus_master.sv
// slave_bus_master: single-request bus sequencer driving CARDSEL/WR_N/AI/DO to the DLX slave, with ack timeout and stray-ack flag
module slave_bus_master #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              CARDSEL,
    output logic              WR_N,
    output logic [ADDR_W-1:0] AI,
    output logic [DATA_W-1:0] DO,
    input  logic [DATA_W-1:0] DI,
    input  logic              SACK_N,
    output logic              stray_ack
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cardsel_q, cardsel_d, wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] ai_q, ai_d;
    logic [DATA_W-1:0] do_q, do_d, rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d, err_q, err_d, stray_q, stray_d;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cardsel_q   <= 1'b0;
            wr_n_q      <= 1'b1;
            ai_q        <= '0;
            do_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cardsel_q   <= cardsel_d;
            wr_n_q      <= wr_n_d;
            ai_q        <= ai_d;
            do_q        <= do_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            stray_q     <= stray_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cardsel_d   = cardsel_q;
        wr_n_d      = wr_n_q;
        ai_d        = ai_q;
        do_d        = do_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        stray_d     = stray_q | (~SACK_N & (state_q != BUS));
        case (state_q)
            IDLE: if (req_valid) begin
                state_d   = BUS;
                cardsel_d = 1'b1;
                wr_n_d    = ~req_write;
                ai_d      = req_addr;
                do_d      = req_wdata;
                cnt_d     = '0;
            end
            BUS: begin
                // ack takes priority over a timeout landing on the same edge
                if (!SACK_N || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    cardsel_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    err_d       = SACK_N;
                    rdata_d     = (!SACK_N && wr_n_q) ? DI : '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign CARDSEL   = cardsel_q;
    assign WR_N      = wr_n_q;
    assign AI        = ai_q;
    assign DO        = do_q;
    assign stray_ack = stray_q;
endmodule

// File: tb/tb_slave_bus_master.sv
// tb_slave_bus_master: directed self-checking bench for slave_bus_master
module tb_slave_bus_master;
    logic        CLK = 1'b0;
    logic        RESET, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic        CARDSEL, WR_N, SACK_N, stray_ack;
    logic [9:0]  req_addr, AI;
    logic [31:0] req_wdata, rsp_rdata, DO, DI;
    int checks = 0;
    int errors = 0;
    int n;
    slave_bus_master dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .CARDSEL(CARDSEL), .WR_N(WR_N), .AI(AI), .DO(DO), .DI(DI), .SACK_N(SACK_N),
        .stray_ack(stray_ack)
    );
    always #5 CLK = ~CLK;
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask
    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, rsp_valid, 0);
        chk({tag, "_ready_back"}, req_ready, 1);
    endtask
    initial begin
        RESET = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 0; DI = '0; SACK_N = 1;
        @(negedge CLK);
        tick();
        tick();
        RESET = 0;
        chk("rst_cardsel", CARDSEL, 0);
        chk("rst_wr_n", WR_N, 1);
        chk("rst_ai", AI, 0);
        chk("rst_do", DO, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_stray", stray_ack, 0);
        chk("rst_req_ready", req_ready, 1);
        // 1: read, ack on first BUS edge
        DI = 32'h0FEDCBA9;
        issue(0, 10'h01F, 32'hAAAA5555);
        chk("t1_cardsel", CARDSEL, 1);
        chk("t1_wr_n", WR_N, 1);
        chk("t1_ai", AI, 10'h01F);
        chk("t1_req_ready", req_ready, 0);
        chk("t1_no_rsp_yet", rsp_valid, 0);
        SACK_N = 0;
        tick();
        SACK_N = 1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rdata", rsp_rdata, 32'h0FEDCBA9);
        chk("t1_err", rsp_err, 0);
        chk("t1_cardsel_low", CARDSEL, 0);
        chk("t1_ai_hold", AI, 10'h01F);
        handshake("t1");
        chk("t1_stray", stray_ack, 0);
        // 2: read with no ack -> timeout after 16 cycles
        DI = 32'hDEADBEEF;
        issue(0, 10'h035, 32'h0);
        n = 0;
        while (CARDSEL && n < 40) begin
            n++;
            chk("t2_no_early_rsp", rsp_valid, 0);
            tick();
        end
        chk("t2_cardsel_cycles", n, 16);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_err", rsp_err, 1);
        chk("t2_rdata", rsp_rdata, 0);
        handshake("t2");
        // 2b: ack on the very edge the timeout would fire -> ack wins
        DI = 32'h5A5A0001;
        issue(0, 10'h036, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("t2b_still_bus", CARDSEL, 1);
        SACK_N = 0;
        tick();
        SACK_N = 1;
        chk("t2b_rsp_valid", rsp_valid, 1);
        chk("t2b_err", rsp_err, 0);
        chk("t2b_rdata", rsp_rdata, 32'h5A5A0001);
        handshake("t2b");
        // 3: write, ack on third edge
        DI = 32'hFFFFFFFF;
        issue(1, 10'h003, 32'h12345678);
        for (int i = 0; i < 2; i++) begin
            chk("t3_wr_n", WR_N, 0);
            chk("t3_do", DO, 32'h12345678);
            chk("t3_cardsel", CARDSEL, 1);
            tick();
        end
        chk("t3_do_3rd", DO, 32'h12345678);
        SACK_N = 0;
        tick();
        SACK_N = 1;
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_err", rsp_err, 0);
        chk("t3_rdata", rsp_rdata, 0);
        chk("t3_wr_n_hold", WR_N, 0);
        handshake("t3");
        // 4: back-to-back reads with stalled response
        DI = 32'h11111111;
        issue(0, 10'h06A, 32'h0);
        SACK_N = 0;
        tick();
        SACK_N = 1;
        DI = 32'h99999999;
        req_valid = 1; req_write = 0; req_addr = 10'h040;
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_rdata", rsp_rdata, 32'h11111111);
            chk("t4_hold_err", rsp_err, 0);
            chk("t4_busy", req_ready, 0);
            chk("t4_bus_idle", CARDSEL, 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t4_rsp_drop", rsp_valid, 0);
        chk("t4_gap_cardsel", CARDSEL, 0);
        chk("t4_gap_ai", AI, 10'h06A);
        tick();
        req_valid = 0;
        chk("t4_2nd_cardsel", CARDSEL, 1);
        chk("t4_2nd_ai", AI, 10'h040);
        DI = 32'h22222222;
        SACK_N = 0;
        tick();
        SACK_N = 1;
        chk("t4_2nd_rdata", rsp_rdata, 32'h22222222);
        handshake("t4");
        // 5: reset during BUS aborts the transaction
        issue(0, 10'h055, 32'h0);
        chk("t5_cardsel", CARDSEL, 1);
        RESET = 1;
        tick();
        RESET = 0;
        chk("t5_cardsel_drop", CARDSEL, 0);
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_req_ready", req_ready, 1);
        SACK_N = 0;
        tick();
        SACK_N = 1;
        chk("t5_still_no_rsp", rsp_valid, 0);
        // 6: SACK_N low in IDLE sets sticky stray_ack (the one above already did)
        chk("t6_stray_set", stray_ack, 1);
        chk("t6_fsm_idle", req_ready, 1);
        chk("t6_no_rsp", rsp_valid, 0);
        DI = 32'h0BADF00D;
        issue(0, 10'h07F, 32'h0);
        SACK_N = 0;
        tick();
        SACK_N = 1;
        chk("t6_rsp_ok", rsp_rdata, 32'h0BADF00D);
        handshake("t6");
        chk("t6_stray_sticky", stray_ack, 1);
        RESET = 1;
        tick();
        RESET = 0;
        chk("t6_stray_clear", stray_ack, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
